// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the 5-stage pipeline hazard logic: 4-bit opcode
//   encodings, the divide-sequencer FSM state type, and helpers that decode
//   which register sources an opcode reads and whether it is a load.
//   Opcodes 13-15 are unassigned and decode like NOP.
package pipeline_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_B    = 4'd1;
  localparam logic [3:0] OP_BEQ  = 4'd2;
  localparam logic [3:0] OP_BLT  = 4'd3;
  localparam logic [3:0] OP_LDW  = 4'd4;
  localparam logic [3:0] OP_LDB  = 4'd5;
  localparam logic [3:0] OP_STW  = 4'd6;
  localparam logic [3:0] OP_STB  = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } div_state_e;

  // Every non-branch, non-NOP opcode reads Rs1 (loads/stores use it as base).
  function automatic logic uses_rs1(input logic [3:0] op);
    return (op >= OP_LDW) && (op <= OP_SHL);
  endfunction

  // Rs2 is the store data or the second ALU operand; ADDI and loads skip it.
  function automatic logic uses_rs2(input logic [3:0] op);
    logic r;
    case (op)
      OP_STW, OP_STB, OP_ADD, OP_SUB, OP_DIV, OP_SHL: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LDW) || (op == OP_LDB);
  endfunction

endpackage

// File: rtl/div_sequencer.sv
// div_sequencer
//   Holds EX while the multicycle divider runs. A DIV seen in EX while in RUN
//   fires a one-cycle start pulse and loads a down-counter; EX stays held
//   until the counter reaches 1, at which point the DIV is allowed to leave.
//   Total EX occupancy is DIV_CYCLES cycles, of which DIV_CYCLES-1 stall.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   op_e        : opcode currently in EX
//   div_start   : divider start pulse
//   div_busy    : divide in progress (both states of an active divide)
//   div_stall   : request to hold IF/ID/EX and bubble MEM
module div_sequencer
  import pipeline_pkg::*;
#(
  parameter int DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] op_e,
  output logic       div_start,
  output logic       div_busy,
  output logic       div_stall
);

  localparam int CNT_W = ($clog2(DIV_CYCLES) < 3) ? 3 : $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_start  = 1'b0;
    div_busy   = 1'b0;
    div_stall  = 1'b0;
    case (state)
      RUN: begin
        if (op_e == OP_DIV) begin
          div_start  = 1'b1;
          div_busy   = 1'b1;
          div_stall  = 1'b1;
          state_next = DIV_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      DIV_WAIT: begin
        div_busy = 1'b1;
        cnt_next = cnt - CNT_ONE;
        // cnt==1 is the release cycle: EX advances on this edge, so the
        // same DIV is not seen again in RUN.
        if (cnt > CNT_ONE) begin
          div_stall = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
//   Stall/flush controller for the IF-ID-EX-MEM-WB pipeline. Combines the
//   divide sequencer with RAW hazard detection and taken-branch squashing.
//   Priority: reset > divide stall > taken branch > data hazard.
//   Build option HAZARD_FORWARD_EN: when defined, forwarding exists and only
//   load-use stalls; otherwise any EX or MEM producer of a used source stalls.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   OpCodeD, Rs1D, Rs2D      : instruction in ID and its source registers
//   OpCodeE, RdE, RegFileWEE : instruction in EX, destination, write enable
//   RdM, RegFileWEM          : MEM destination and write enable
//   BranchTakenE             : branch in EX resolved taken
//   StallF, StallD, StallE   : hold PC / IF-ID / ID-EX
//   FlushD, FlushE, FlushM   : clear IF-ID / ID-EX / EX-MEM to NOP
//   DivStart, DivBusy        : divider start pulse and busy status
module pipeline_hazard_sequencer
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            OpCodeD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [3:0]            OpCodeE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegFileWEE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegFileWEM,
  input  logic                  BranchTakenE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  DivStart,
  output logic                  DivBusy
);

  logic div_start, div_busy, div_stall;

  div_sequencer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk      (clk),
    .rst      (rst),
    .op_e     (OpCodeE),
    .div_start(div_start),
    .div_busy (div_busy),
    .div_stall(div_stall)
  );

  logic use1, use2, match_e, data_hazard, branch_eff;

  assign use1    = uses_rs1(OpCodeD);
  assign use2    = uses_rs2(OpCodeD);
  assign match_e = RegFileWEE && ((use1 && (Rs1D == RdE)) || (use2 && (Rs2D == RdE)));

`ifdef HAZARD_FORWARD_EN
  logic unused_m;
  assign unused_m    = ^{RdM, RegFileWEM};
  assign data_hazard = match_e && is_load(OpCodeE);
`else
  logic match_m;
  assign match_m     = RegFileWEM && ((use1 && (Rs1D == RdM)) || (use2 && (Rs2D == RdM)));
  assign data_hazard = match_e || match_m;
`endif

  // A branch cannot share EX with a DIV, so busy means DIV_WAIT here and any
  // branch indication then is spurious.
  assign branch_eff = BranchTakenE && !div_busy;

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    DivStart = 1'b0;
    DivBusy  = 1'b0;
    if (!rst) begin
      DivStart = div_start;
      DivBusy  = div_busy;
      if (div_stall) begin
        // ID/EX is held, so it must not also be cleared.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (branch_eff) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (data_hazard) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer (DIV_CYCLES=8). Output vector
// order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, DivStart, DivBusy}.
// Expectations depending on forwarding follow HAZARD_FORWARD_EN.
module tb_pipeline_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op_d, rs1_d, rs2_d, op_e, rd_e, rd_m;
  logic       we_e, we_m, br_e;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_start, div_busy;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] NONE   = 8'b0000_0000;
  localparam logic [7:0] HAZ    = 8'b1100_1000;
  localparam logic [7:0] DIVS0  = 8'b1110_0111;
  localparam logic [7:0] DIVW   = 8'b1110_0101;
  localparam logic [7:0] DIVREL = 8'b0000_0001;
  localparam logic [7:0] BR     = 8'b0001_1000;

`ifdef HAZARD_FORWARD_EN
  localparam logic [7:0] NOFWD_HAZ = NONE;
`else
  localparam logic [7:0] NOFWD_HAZ = HAZ;
`endif

  wire [7:0] outs = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_start, div_busy};

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .REG_ADDR_W(4),
    .DIV_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .OpCodeD     (op_d),
    .Rs1D        (rs1_d),
    .Rs2D        (rs2_d),
    .OpCodeE     (op_e),
    .RdE         (rd_e),
    .RegFileWEE  (we_e),
    .RdM         (rd_m),
    .RegFileWEM  (we_m),
    .BranchTakenE(br_e),
    .StallF      (stall_f),
    .StallD      (stall_d),
    .StallE      (stall_e),
    .FlushD      (flush_d),
    .FlushE      (flush_e),
    .FlushM      (flush_m),
    .DivStart    (div_start),
    .DivBusy     (div_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op_d = 4'd0; rs1_d = 4'd0; rs2_d = 4'd0;
    op_e = 4'd0; rd_e = 4'd0; we_e = 1'b0;
    rd_m = 4'd0; we_m = 1'b0; br_e = 1'b0;
  endtask

  // Hand-derived divide timeline for DIV_CYCLES=8, cycle k after DIV enters EX.
  function automatic logic [7:0] exp_div(input int k);
    if (k == 0)      return DIVS0;
    else if (k <= 6) return DIVW;
    else if (k == 7) return DIVREL;
    else             return NONE;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    op_e = 4'd11; op_d = 4'd8; rs2_d = 4'd3; rd_e = 4'd3; we_e = 1'b1; br_e = 1'b1;
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL reset_outputs: got %b want %b", outs, NONE); end
    step();
    step();
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL reset_held: got %b want %b", outs, NONE); end
    rst = 1'b0;
    idle();
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL reset_idle: got %b want %b", outs, NONE); end
    step();
  endtask

  task automatic test_load_use();
    idle();
    op_e = 4'd4; rd_e = 4'd3; we_e = 1'b1; op_d = 4'd8; rs1_d = 4'd1; rs2_d = 4'd3;
    #1;
    total++;
    if (outs !== HAZ) begin bad++; $display("FAIL load_use_rs2: got %b want %b", outs, HAZ); end
    step();
    // load moved to MEM, bubble in EX
    idle();
    op_d = 4'd8; rs1_d = 4'd1; rs2_d = 4'd3; rd_m = 4'd3; we_m = 1'b1;
    #1;
    total++;
    if (outs !== NOFWD_HAZ) begin bad++; $display("FAIL load_use_after: got %b want %b", outs, NOFWD_HAZ); end
    step();
    idle();
    op_e = 4'd4; rd_e = 4'd3; we_e = 1'b1; op_d = 4'd1; rs1_d = 4'd3; rs2_d = 4'd3;
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL load_use_branch_in_d: got %b want %b", outs, NONE); end
    step();
    op_d = 4'd4; rs1_d = 4'd2; rs2_d = 4'd3;
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL load_rs2_unused: got %b want %b", outs, NONE); end
    step();
    op_e = 4'd5; rd_e = 4'd0; op_d = 4'd9; rs1_d = 4'd0;
    #1;
    total++;
    if (outs !== HAZ) begin bad++; $display("FAIL load_use_r0: got %b want %b", outs, HAZ); end
    step();
    we_e = 1'b0;
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL load_no_we: got %b want %b", outs, NONE); end
    step();
  endtask

  task automatic test_divide();
    for (int k = 0; k <= 8; k++) begin
      idle();
      op_e = (k < 8) ? 4'd11 : 4'd0;
      if (k == 2 || k == 7) br_e = 1'b1;
      if (k == 4) begin
        op_d = 4'd8; rs1_d = 4'd7; rd_m = 4'd7; we_m = 1'b1;
      end
      #1;
      total++;
      if (outs !== exp_div(k)) begin
        bad++;
        $display("FAIL divide cyc %0d: got %b want %b", k, outs, exp_div(k));
      end
      step();
    end
  endtask

  task automatic test_branch_hazard();
    idle();
    op_e = 4'd4; rd_e = 4'd3; we_e = 1'b1; op_d = 4'd8; rs2_d = 4'd3; br_e = 1'b1;
    #1;
    total++;
    if (outs !== BR) begin bad++; $display("FAIL branch_over_load_use: got %b want %b", outs, BR); end
    step();
    idle();
    op_e = 4'd2; br_e = 1'b1;
    #1;
    total++;
    if (outs !== BR) begin bad++; $display("FAIL branch_alone: got %b want %b", outs, BR); end
    step();
    br_e = 1'b0;
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL branch_not_taken: got %b want %b", outs, NONE); end
    step();
  endtask

  task automatic test_reset_mid_div();
    for (int k = 0; k < 3; k++) begin
      idle();
      op_e = 4'd11;
      #1;
      total++;
      if (outs !== exp_div(k)) begin bad++; $display("FAIL pre_reset_div cyc %0d: got %b want %b", k, outs, exp_div(k)); end
      step();
    end
    rst = 1'b1;
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL reset_mid_div: got %b want %b", outs, NONE); end
    step();
    rst = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      idle();
      op_e = (k < 8) ? 4'd11 : 4'd0;
      #1;
      total++;
      if (outs !== exp_div(k)) begin bad++; $display("FAIL post_reset_div cyc %0d: got %b want %b", k, outs, exp_div(k)); end
      step();
    end
  endtask

  task automatic test_no_forward();
    idle();
    op_e = 4'd8; rd_e = 4'd5; we_e = 1'b1; op_d = 4'd9; rs1_d = 4'd5;
    #1;
    total++;
    if (outs !== NOFWD_HAZ) begin bad++; $display("FAIL nofwd_ex: got %b want %b", outs, NOFWD_HAZ); end
    step();
    for (int k = 0; k < 2; k++) begin
      idle();
      op_d = 4'd9; rs1_d = 4'd5; rd_m = 4'd5; we_m = 1'b1;
      #1;
      total++;
      if (outs !== NOFWD_HAZ) begin bad++; $display("FAIL nofwd_mem rep %0d: got %b want %b", k, outs, NOFWD_HAZ); end
      step();
    end
    rd_m = 4'd6;
    #1;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL nofwd_passed: got %b want %b", outs, NONE); end
    step();
  endtask

  task automatic test_back_to_back();
    int starts = 0;
    int first = -1;
    int second = -1;
    for (int k = 0; k <= 16; k++) begin
      logic [7:0] e;
      idle();
      op_e = (k < 16) ? 4'd11 : 4'd0;
      e = (k == 16) ? NONE : exp_div(k % 8);
      #1;
      if (div_start === 1'b1) begin
        starts++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
      total++;
      if (outs !== e) begin bad++; $display("FAIL b2b cyc %0d: got %b want %b", k, outs, e); end
      step();
    end
    total++;
    if (starts != 2 || (second - first) != 8) begin
      bad++;
      $display("FAIL b2b_starts: got count %0d gap %0d want count 2 gap 8", starts, second - first);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_branch_hazard();
    test_reset_mid_div();
    test_no_forward();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
# pipeline_hazard_sequencer

Sequential hazard and stall controller for the 5-stage pipeline (IF, ID, EX, MEM, WB) driven by the 4-bit opcode control unit. It detects register read-after-write hazards between ID and later stages and squashes wrong-path instructions on taken branches. It also sequences the multicycle divider: it holds EX for `DIV_CYCLES` cycles and issues the divider start pulse. Outputs drive pipeline-register enables and clears.

## Interface
- `REG_ADDR_W`, default 4: register-address width.
- `DIV_CYCLES`, default 8: total EX occupancy of `DIV`; minimum 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `OpCodeD` in 4: opcode in ID.
- `Rs1D`, `Rs2D` in `REG_ADDR_W`: ID source registers.
- `OpCodeE` in 4: opcode in EX.
- `RdE` in `REG_ADDR_W`: EX destination.
- `RegFileWEE` in 1: EX writes the register file.
- `RdM` in `REG_ADDR_W`: MEM destination.
- `RegFileWEM` in 1: MEM writes the register file.
- `BranchTakenE` in 1: branch in EX resolved taken.
- `StallF`, `StallD` out 1: hold the PC and the IF/ID register.
- `StallE` out 1: hold the ID/EX register.
- `FlushD`, `FlushE`, `FlushM` out 1: clear IF/ID, ID/EX, EX/MEM to NOP.
- `DivStart` out 1: one-cycle divider start pulse.
- `DivBusy` out 1: divide in progress.

## Operation
- Opcodes: NOP 0, B 1, BEQ 2, BLT 3, LDW 4, LDB 5, STW 6, STB 7, ADD 8, ADDI 9, SUB 10, DIV 11, SHL 12; 13–15 are treated as NOP.
- Source use by `OpCodeD`:
  - Rs1 is read by 4–12.
  - Rs2 is read by 6, 7, 8, 10, 11, 12.
  - NOP and branches read no registers.
  - No register number is exempt.
- Load-use hazard: `OpCodeE` ∈ {LDW, LDB}, `RegFileWEE`, and `RdE` equals a used source → `StallF`, `StallD`, `FlushE`.
- FSM states: `RUN`, `DIV_WAIT`; 3-bit-minimum down-counter `cnt`, width clog2(`DIV_CYCLES`).
- `RUN` with `OpCodeE`=DIV:
  - `DivStart`=1, `DivBusy`=1.
  - `StallF`, `StallD`, `StallE`, `FlushM` asserted.
  - Next state `DIV_WAIT`, `cnt` ← `DIV_CYCLES`-1.
- `DIV_WAIT`:
  - `DivBusy`=1; `cnt` decrements each cycle.
  - While `cnt`>1: `StallF`, `StallD`, `StallE`, `FlushM` asserted.
  - At `cnt`==1: stalls release, `DivBusy` stays 1, next state `RUN`. The `DIV` leaves EX on that edge and is not restarted.
- Branch: `BranchTakenE` → `FlushD`=1, `FlushE`=1, no stalls. The branch overrides load-use detection in the same cycle.
- Simultaneous events:
  - Div stall overrides load-use; `FlushE` is 0 while `StallE`=1.
  - `BranchTakenE` cannot coincide with `DIV` in EX; if asserted in `DIV_WAIT` it is ignored.
- Back-to-back `DIV`: the second enters EX on the release edge and starts from `RUN` on the next cycle.

## Timing
- All outputs are combinational from state, `cnt`, and inputs; there are no output registers.
- While `rst`=1, all outputs are 0.
- Reset takes effect on the next edge: state ← `RUN`, `cnt` ← 0.
- Reset mid-divide abandons the divide; the first post-reset cycle is `RUN`.
- Load-use stall lasts exactly 1 cycle.
- `DIV` costs `DIV_CYCLES`-1 stall cycles.
- Branch penalty is 2 flushed instructions.
- `DivStart` is high for exactly one cycle per `DIV`.

## Configuration
- `HAZARD_FORWARD_EN` defined (forwarding present):
  - Only the load-use rule stalls.
  - `RdM` and `RegFileWEM` are unused.
- `HAZARD_FORWARD_EN` undefined (no forwarding):
  - Stall if a used source equals `RdE` with `RegFileWEE`, or `RdM` with `RegFileWEM`, for any opcode.
  - Response is `StallF`, `StallD`, `FlushE`, repeated each cycle until the producer passes MEM.

## Structure
- Shared package `pipeline_pkg`:
  - opcode enum/localparams;
  - FSM state typedef;
  - functions `uses_rs1(op)` and `uses_rs2(op)`;
  - `is_load(op)`.
- Sub-module `div_sequencer`: the FSM plus counter, producing `DivStart`, `DivBusy`, and the div-stall request. The top level combines it with hazard and branch logic and the priority rules.

## Test plan
- Load-use: `OpCodeE`=4, `RdE`=3, `RegFileWEE`=1, `OpCodeD`=8, `Rs2D`=3 → `StallF`=`StallD`=`FlushE`=1 for one cycle. `OpCodeD`=1 gives no stall.
- Divide, `DIV_CYCLES`=8: `OpCodeE`=11 held in EX → `DivStart` pulse in cycle 0; `StallE`=`FlushM`=1 for cycles 0–6; cycle 7 no stall with `DivBusy`=1; cycle 8 `DivBusy`=0.
- Branch plus hazard: `BranchTakenE`=1 while the load-use condition holds → `FlushD`=`FlushE`=1, `StallF`=0.
- Reset at divide cycle 3 → outputs 0 during reset; next cycle `RUN`; a new `OpCodeE`=11 issues a fresh `DivStart`.
- No forwarding: `OpCodeE`=8, `RdE`=5, `RegFileWEE`=1, `OpCodeD`=9, `Rs1D`=5 → stall. Stall repeats while `RdM`=5, `RegFileWEM`=1; it is absent with `HAZARD_FORWARD_EN`.
- Back-to-back `DIV` → two `DivStart` pulses 8 cycles apart.
